// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the call/return stack sequencer.
// Contents: PC/flags widths, depth counter width, default stack depth and
// interrupt vector, the operation and FSM-state enums.
package cpu_pkg;

  localparam int unsigned PC_W    = 9;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned DEPTH_W = 3;

  localparam int unsigned   DEFAULT_DEPTH   = 5;
  localparam logic [PC_W-1:0] DEFAULT_IRQ_VEC = 9'h1F0;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CALL,
    OP_RET,
    OP_RETI,
    OP_IRQ
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ACK
  } state_t;

endpackage

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: sequences the return-address/flags stack for CALL, RET,
// RETI and interrupt entry, arbitrating decoder requests against the IRQ line.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   call_req/ret_req/reti_req      decoder requests, held until done
//   irq_req                        level interrupt, sampled only in IDLE
//   call_target, cur_pc, cur_flags request operands
//   stk_pc, stk_flags              combinational stack top
//   push_en/pop_en, push_pc/flags  stack strobes and write data
//   pc_load/pc_next                PC reload
//   flags_load/flags_next          flags reload
//   busy, done, irq_ack            handshake / status pulses
//   irq_active, depth              ISR state, entries in use
//   overflow, underflow            sticky error flags (cleared by rst only)
//
// Build option: NESTED_IRQ_EN allows interrupts inside an ISR and tracks the
// nesting with a 3-bit level counter; otherwise irq_req is masked in an ISR.
//
// Timing: request sampled in IDLE (cycle T), strobes registered for T+1
// (EXEC), done in T+2 (ACK), new request accepted from T+3.
module call_stack_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned      DEPTH   = DEFAULT_DEPTH,
  parameter logic [PC_W-1:0]  IRQ_VEC = DEFAULT_IRQ_VEC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                call_req,
  input  logic                ret_req,
  input  logic                reti_req,
  input  logic                irq_req,
  input  logic [PC_W-1:0]     call_target,
  input  logic [PC_W-1:0]     cur_pc,
  input  logic [FLAGS_W-1:0]  cur_flags,
  input  logic [PC_W-1:0]     stk_pc,
  input  logic [FLAGS_W-1:0]  stk_flags,
  output logic                push_en,
  output logic                pop_en,
  output logic [PC_W-1:0]     push_pc,
  output logic [FLAGS_W-1:0]  push_flags,
  output logic                pc_load,
  output logic [PC_W-1:0]     pc_next,
  output logic                flags_load,
  output logic [FLAGS_W-1:0]  flags_next,
  output logic                busy,
  output logic                done,
  output logic                irq_ack,
  output logic                irq_active,
  output logic [DEPTH_W-1:0]  depth,
  output logic                overflow,
  output logic                underflow
);

  state_t state, state_next;
  op_t    op, win_op;
  logic   irq_ok;
  logic   full, empty;

  logic                push_en_d, pop_en_d, pc_load_d, flags_load_d;
  logic                busy_d, done_d, irq_ack_d;
  logic [PC_W-1:0]     push_pc_d, pc_next_d;
  logic [FLAGS_W-1:0]  push_flags_d, flags_next_d;
  logic [DEPTH_W-1:0]  depth_next;
  logic                overflow_next, underflow_next, irq_active_next;

  assign full  = (depth == DEPTH_W'(DEPTH));
  assign empty = (depth == DEPTH_W'(0));

`ifdef NESTED_IRQ_EN
  logic [2:0] irq_level, irq_level_next;

  // Interrupts nest; only a saturated level counter blocks another entry.
  assign irq_ok = irq_req && (irq_level != 3'd7);

  // Level counts ISRs actually entered/left (suppressed ops do not count).
  always_comb begin
    irq_level_next = irq_level;
    if (state == S_EXEC) begin
      if (op == OP_IRQ && push_en)
        irq_level_next = irq_level + 3'd1;
      else if (op == OP_RETI && pop_en && irq_level != 3'd0)
        irq_level_next = irq_level - 3'd1;
    end
  end

  assign irq_active_next = (irq_level_next != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) irq_level <= 3'd0;
    else     irq_level <= irq_level_next;
  end
`else
  // Single-level ISR: further interrupts wait until RETI.
  assign irq_ok = irq_req && !irq_active;

  always_comb begin
    irq_active_next = irq_active;
    if (state == S_EXEC) begin
      if (op == OP_IRQ && push_en)
        irq_active_next = 1'b1;
      else if (op == OP_RETI && pop_en)
        irq_active_next = 1'b0;
    end
  end
`endif

  // Fixed-priority arbiter: irq > reti > ret > call.
  always_comb begin
    win_op = OP_NONE;
    if (irq_ok)        win_op = OP_IRQ;
    else if (reti_req) win_op = OP_RETI;
    else if (ret_req)  win_op = OP_RET;
    else if (call_req) win_op = OP_CALL;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op    <= OP_NONE;
    end else begin
      state <= state_next;
      if (state == S_IDLE) op <= win_op;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (win_op != OP_NONE) state_next = S_EXEC;
      S_EXEC:  state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: values registered so they appear in the following cycle.
  // EXEC-cycle strobes are therefore decided while still in IDLE; the stack
  // top and request operands are stable across both cycles.
  always_comb begin
    push_en_d    = 1'b0;
    pop_en_d     = 1'b0;
    pc_load_d    = 1'b0;
    flags_load_d = 1'b0;
    irq_ack_d    = 1'b0;
    push_pc_d    = push_pc;
    push_flags_d = push_flags;
    pc_next_d    = pc_next;
    flags_next_d = flags_next;
    busy_d       = (state_next != S_IDLE);
    done_d       = (state == S_EXEC);

    if (state == S_IDLE) begin
      case (win_op)
        OP_CALL: if (!full) begin
          push_en_d    = 1'b1;
          push_pc_d    = cur_pc;
          push_flags_d = cur_flags;
          pc_load_d    = 1'b1;
          pc_next_d    = call_target;
        end
        OP_IRQ: if (!full) begin
          // Stack stores in_pc+1, so push cur_pc-1 to resume at cur_pc.
          push_en_d    = 1'b1;
          push_pc_d    = cur_pc - PC_W'(1);
          push_flags_d = cur_flags;
          pc_load_d    = 1'b1;
          pc_next_d    = IRQ_VEC;
          irq_ack_d    = 1'b1;
        end
        OP_RET: if (!empty) begin
          pop_en_d  = 1'b1;
          pc_load_d = 1'b1;
          pc_next_d = stk_pc;
        end
        OP_RETI: if (!empty) begin
          pop_en_d     = 1'b1;
          pc_load_d    = 1'b1;
          pc_next_d    = stk_pc;
          flags_load_d = 1'b1;
          flags_next_d = stk_flags;
        end
        default: ;
      endcase
    end
  end

  // Depth and sticky errors resolve during EXEC from the latched op.
  always_comb begin
    depth_next     = depth;
    overflow_next  = overflow;
    underflow_next = underflow;
    if (state == S_EXEC) begin
      if (push_en)
        depth_next = depth + DEPTH_W'(1);
      else if (pop_en)
        depth_next = depth - DEPTH_W'(1);
      if ((op == OP_CALL || op == OP_IRQ) && !push_en)
        overflow_next = 1'b1;
      if ((op == OP_RET || op == OP_RETI) && !pop_en)
        underflow_next = 1'b1;
    end
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_en    <= 1'b0;
      pop_en     <= 1'b0;
      pc_load    <= 1'b0;
      flags_load <= 1'b0;
      irq_ack    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      push_pc    <= '0;
      push_flags <= '0;
      pc_next    <= '0;
      flags_next <= '0;
      depth      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      irq_active <= 1'b0;
    end else begin
      push_en    <= push_en_d;
      pop_en     <= pop_en_d;
      pc_load    <= pc_load_d;
      flags_load <= flags_load_d;
      irq_ack    <= irq_ack_d;
      busy       <= busy_d;
      done       <= done_d;
      push_pc    <= push_pc_d;
      push_flags <= push_flags_d;
      pc_next    <= pc_next_d;
      flags_next <= flags_next_d;
      depth      <= depth_next;
      overflow   <= overflow_next;
      underflow  <= underflow_next;
      irq_active <= irq_active_next;
    end
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: directed requests push expected
// transactions into a queue; a monitor snapshots the EXEC-cycle strobes and
// compares them, plus post-op depth/error/ISR state, on each done pulse.
module tb_call_stack_ctrl;
  import cpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                call_req, ret_req, reti_req, irq_req;
  logic [PC_W-1:0]     call_target, cur_pc, stk_pc;
  logic [FLAGS_W-1:0]  cur_flags, stk_flags;
  logic                push_en, pop_en, pc_load, flags_load;
  logic [PC_W-1:0]     push_pc, pc_next;
  logic [FLAGS_W-1:0]  push_flags, flags_next;
  logic                busy, done, irq_ack, irq_active, overflow, underflow;
  logic [DEPTH_W-1:0]  depth;

  always #5 clk = ~clk;

  call_stack_ctrl dut (
    .clk(clk), .rst(rst),
    .call_req(call_req), .ret_req(ret_req), .reti_req(reti_req), .irq_req(irq_req),
    .call_target(call_target), .cur_pc(cur_pc), .cur_flags(cur_flags),
    .stk_pc(stk_pc), .stk_flags(stk_flags),
    .push_en(push_en), .pop_en(pop_en), .push_pc(push_pc), .push_flags(push_flags),
    .pc_load(pc_load), .pc_next(pc_next), .flags_load(flags_load), .flags_next(flags_next),
    .busy(busy), .done(done), .irq_ack(irq_ack), .irq_active(irq_active),
    .depth(depth), .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    logic               push, pop, pcl, fl, ack;
    logic [PC_W-1:0]    ppc;
    logic [FLAGS_W-1:0] pfl;
    logic [PC_W-1:0]    pcn;
    logic [FLAGS_W-1:0] fln;
    logic [2:0]         dep;
    logic               ovf, unf, act;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   lat;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic exp_push(input logic ok, input logic ack, input logic [PC_W-1:0] ppc,
                          input logic [FLAGS_W-1:0] pfl, input logic [PC_W-1:0] pcn,
                          input logic [2:0] dep, input logic ovf, input logic unf,
                          input logic act);
    exp_t e;
    e.push = ok; e.pop = 1'b0; e.pcl = ok; e.fl = 1'b0; e.ack = ack;
    e.ppc = ppc; e.pfl = pfl; e.pcn = pcn; e.fln = '0;
    e.dep = dep; e.ovf = ovf; e.unf = unf; e.act = act;
    q.push_back(e);
  endtask

  task automatic exp_pop(input logic ok, input logic fl, input logic [PC_W-1:0] pcn,
                         input logic [FLAGS_W-1:0] fln, input logic [2:0] dep,
                         input logic ovf, input logic unf, input logic act);
    exp_t e;
    e.push = 1'b0; e.pop = ok; e.pcl = ok; e.fl = fl; e.ack = 1'b0;
    e.ppc = '0; e.pfl = '0; e.pcn = pcn; e.fln = fln;
    e.dep = dep; e.ovf = ovf; e.unf = unf; e.act = act;
    q.push_back(e);
  endtask

  // Monitor: capture EXEC strobes, check them and the post-op state on done.
  logic               s_push, s_pop, s_pcl, s_fl, s_ack;
  logic [PC_W-1:0]    s_ppc, s_pcn;
  logic [FLAGS_W-1:0] s_pfl, s_fln;
  exp_t               m;

  always @(negedge clk) begin
    if (!rst && busy && !done) begin
      s_push = push_en; s_pop = pop_en; s_pcl = pc_load; s_fl = flags_load;
      s_ack = irq_ack; s_ppc = push_pc; s_pfl = push_flags;
      s_pcn = pc_next; s_fln = flags_next;
    end
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        m = q.pop_front();
        chk("push_pop_exclusive", 32'(s_push & s_pop), 32'd0);
        chk("push_en", 32'(s_push), 32'(m.push));
        chk("pop_en", 32'(s_pop), 32'(m.pop));
        chk("pc_load", 32'(s_pcl), 32'(m.pcl));
        chk("flags_load", 32'(s_fl), 32'(m.fl));
        chk("irq_ack", 32'(s_ack), 32'(m.ack));
        if (m.push) begin
          chk("push_pc", 32'(s_ppc), 32'(m.ppc));
          chk("push_flags", 32'(s_pfl), 32'(m.pfl));
        end
        if (m.pcl) chk("pc_next", 32'(s_pcn), 32'(m.pcn));
        if (m.fl)  chk("flags_next", 32'(s_fln), 32'(m.fln));
        chk("depth", 32'(depth), 32'(m.dep));
        chk("overflow", 32'(overflow), 32'(m.ovf));
        chk("underflow", 32'(underflow), 32'(m.unf));
        chk("irq_active", 32'(irq_active), 32'(m.act));
      end
    end
  end

  task automatic set_reqs(input logic c, input logic r, input logic ri, input logic i);
    call_req = c; ret_req = r; reti_req = ri; irq_req = i;
  endtask

  // Wait (bounded) for done; returns the number of negedges taken.
  task automatic wait_done(input string name, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        n = k;
        break;
      end
    end
    if (n == 0) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    set_reqs(0, 0, 0, 0);
    call_target = '0; cur_pc = '0; cur_flags = '0; stk_pc = '0; stk_flags = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({push_en, pop_en, pc_load, flags_load, done, irq_ack}), 32'd0);
    chk("rst_status", 32'({irq_active, overflow, underflow}), 32'd0);
    chk("rst_pc_next", 32'(pc_next), 32'd0);
    chk("rst_push_pc", 32'(push_pc), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: CALL
    cur_pc = 9'h010; call_target = 9'h080; cur_flags = 4'hA;
    exp_push(1, 0, 9'h010, 4'hA, 9'h080, 3'd1, 0, 0, 0);
    set_reqs(1, 0, 0, 0);
    wait_done("t1_call", lat);
    chk("t1_latency", 32'(lat), 32'd2);
    set_reqs(0, 0, 0, 0);

    // 2: RET
    stk_pc = 9'h011; stk_flags = 4'h3;
    exp_pop(1, 0, 9'h011, 4'h0, 3'd0, 0, 0, 0);
    set_reqs(0, 1, 0, 0);
    wait_done("t2_ret", lat);
    set_reqs(0, 0, 0, 0);

    // 3: IRQ and CALL together; IRQ first, CALL after
    cur_pc = 9'h020; call_target = 9'h0C0; cur_flags = 4'h5;
    exp_push(1, 1, 9'h01F, 4'h5, 9'h1F0, 3'd1, 0, 0, 1);
    exp_push(1, 0, 9'h020, 4'h5, 9'h0C0, 3'd2, 0, 0, 1);
    set_reqs(1, 0, 0, 1);
    wait_done("t3_irq", lat);
    set_reqs(1, 0, 0, 0);
    wait_done("t3_call", lat);
    set_reqs(0, 0, 0, 0);

    // 6: interrupt during ISR
    cur_pc = 9'h030;
`ifdef NESTED_IRQ_EN
    exp_push(1, 1, 9'h02F, 4'h5, 9'h1F0, 3'd3, 0, 0, 1);
    set_reqs(0, 0, 0, 1);
    wait_done("t6_nested_irq", lat);
    set_reqs(0, 0, 0, 0);
    stk_pc = 9'h030; stk_flags = 4'h6;
    exp_pop(1, 1, 9'h030, 4'h6, 3'd2, 0, 0, 1);
    set_reqs(0, 0, 1, 0);
    wait_done("t6_reti_inner", lat);
    set_reqs(0, 0, 0, 0);
    stk_pc = 9'h021;
    exp_pop(1, 0, 9'h021, 4'h0, 3'd1, 0, 0, 1);
    set_reqs(0, 1, 0, 0);
    wait_done("t6_ret", lat);
    set_reqs(0, 0, 0, 0);
    stk_pc = 9'h020; stk_flags = 4'h5;
    exp_pop(1, 1, 9'h020, 4'h5, 3'd0, 0, 0, 0);
    set_reqs(0, 0, 1, 0);
    wait_done("t6_reti_outer", lat);
    set_reqs(0, 0, 0, 0);
`else
    set_reqs(0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t6_irq_masked", 32'({busy, irq_ack}), 32'd0);
    end
    stk_pc = 9'h021;
    exp_pop(1, 0, 9'h021, 4'h0, 3'd1, 0, 0, 1);
    set_reqs(0, 1, 0, 1);
    wait_done("t6_ret", lat);
    stk_pc = 9'h020; stk_flags = 4'h5;
    exp_pop(1, 1, 9'h020, 4'h5, 3'd0, 0, 0, 0);
    exp_push(1, 1, 9'h02F, 4'h5, 9'h1F0, 3'd1, 0, 0, 1);
    set_reqs(0, 0, 1, 1);
    wait_done("t6_reti", lat);
    set_reqs(0, 0, 0, 1);
    wait_done("t6_irq", lat);
    set_reqs(0, 0, 0, 0);
    stk_pc = 9'h030; stk_flags = 4'h6;
    exp_pop(1, 1, 9'h030, 4'h6, 3'd0, 0, 0, 0);
    set_reqs(0, 0, 1, 0);
    wait_done("t6_reti2", lat);
    set_reqs(0, 0, 0, 0);
`endif

    // 4: six CALLs from depth 0; the sixth overflows
    cur_flags = 4'h1;
    for (int i = 0; i < 6; i++) begin
      cur_pc = 9'(9'h100 + i);
      call_target = 9'(9'h140 + i);
      exp_push(i < 5, 0, 9'(9'h100 + i), 4'h1, 9'(9'h140 + i),
               (i < 5) ? 3'(i + 1) : 3'd5, i == 5, 0, 0);
      set_reqs(1, 0, 0, 0);
      wait_done("t4_call", lat);
      set_reqs(0, 0, 0, 0);
    end

    // 5: drain, then RET at depth 0 underflows
    for (int i = 0; i < 5; i++) begin
      stk_pc = 9'(9'h180 + i);
      exp_pop(1, 0, 9'(9'h180 + i), 4'h0, 3'(4 - i), 1, 0, 0);
      set_reqs(0, 1, 0, 0);
      wait_done("t5_ret", lat);
      set_reqs(0, 0, 0, 0);
    end
    exp_pop(0, 0, 9'h000, 4'h0, 3'd0, 1, 1, 0);
    set_reqs(0, 1, 0, 0);
    wait_done("t5_underflow", lat);
    set_reqs(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("t5_sticky", 32'({overflow, underflow}), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_clears", 32'({overflow, underflow}), 32'd0);
    chk("t5_rst_depth", 32'(depth), 32'd0);

    // rst mid-op drops the in-flight CALL
    cur_pc = 9'h050; call_target = 9'h0A0;
    set_reqs(1, 0, 0, 0);
    @(negedge clk);
    chk("midrst_exec_push", 32'(push_en), 32'd1);
    rst = 1'b1;
    set_reqs(0, 0, 0, 0);
    @(negedge clk);
    chk("midrst_strobes", 32'({push_en, pc_load, busy, done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_done", 32'(done), 32'd0);
    chk("midrst_depth", 32'(depth), 32'd0);

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
